// File: rtl/ex_stage_md_if.sv
// ex_stage_md_if: ID/EX inputs and registered EX/MEM outputs of the EX stage
interface ex_stage_md_if #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
);
   logic              in_valid;
   logic              flush;
   logic [DATA_W-1:0] id_read_data1;
   logic [DATA_W-1:0] id_read_data2;
   logic [DATA_W-1:0] id_imm;
   logic [REG_AW-1:0] id_rt;
   logic [REG_AW-1:0] id_rd;
   logic [5:0]        funct;
   logic [1:0]        alu_op;
   logic              alu_src;
   logic              reg_dst;
   logic [DATA_W-1:0] mem_fwd_data;
   logic [DATA_W-1:0] wb_fwd_data;
   logic [1:0]        forward_a;
   logic [1:0]        forward_b;
   logic              ex_stall;
   logic              ex_valid;
   logic [DATA_W-1:0] ex_alu_result;
   logic [DATA_W-1:0] ex_store_data;
   logic [REG_AW-1:0] ex_reg_dest;
   modport master (
      output in_valid, flush, id_read_data1, id_read_data2, id_imm, id_rt, id_rd, funct,
             alu_op, alu_src, reg_dst, mem_fwd_data, wb_fwd_data, forward_a, forward_b,
      input  ex_stall, ex_valid, ex_alu_result, ex_store_data, ex_reg_dest
   );
   modport slave (
      input  in_valid, flush, id_read_data1, id_read_data2, id_imm, id_rt, id_rd, funct,
             alu_op, alu_src, reg_dst, mem_fwd_data, wb_fwd_data, forward_a, forward_b,
      output ex_stall, ex_valid, ex_alu_result, ex_store_data, ex_reg_dest
   );
endinterface

// File: rtl/ex_stage_md.sv
// ex_stage_md: MIPS EX stage with forwarding, ALU, EX/MEM register and an iterative mul/div unit
module ex_stage_md #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
) (
   input logic          clk,
   input logic          rst_n,
   ex_stage_md_if.slave bus
);
   localparam int CW = $clog2(DATA_W + 1);
   typedef enum logic {IDLE, RUN} state_t;
   state_t              state, state_nxt;
   logic [DATA_W-1:0]   op_a, fwd_b, op_b, alu_res, a_mag, b_mag;
   logic [DATA_W-1:0]   hi, lo, m, a_orig, hi_nxt, lo_nxt, q_fix, r_fix;
   logic [2*DATA_W-1:0] p, p_step, prod;
   logic [DATA_W:0]     mul_sum, div_sh, div_diff;
   logic [CW-1:0]       count;
   logic                is_div, neg_q, neg_r, div0, a_neg, b_neg, sgn;
   logic                busy, stall, is_md, md_go, alu_go, done;
   logic                ex_valid;
   logic [DATA_W-1:0]   ex_alu_result, ex_store_data;
   logic [REG_AW-1:0]   ex_reg_dest;
   always_comb begin
      op_a = bus.forward_a == 2'b01 ? bus.wb_fwd_data :
             bus.forward_a == 2'b10 ? bus.mem_fwd_data : bus.id_read_data1;
      fwd_b = bus.forward_b == 2'b01 ? bus.wb_fwd_data :
              bus.forward_b == 2'b10 ? bus.mem_fwd_data : bus.id_read_data2;
      op_b = bus.alu_src ? bus.id_imm : fwd_b;
   end
   assign busy   = state == RUN;
   assign stall  = busy && bus.in_valid;
   assign is_md  = bus.alu_op == 2'b10 && bus.funct[5:2] == 4'b0110;
   assign md_go  = bus.in_valid && is_md && !busy && !bus.flush;
   assign alu_go = bus.in_valid && !stall && !bus.flush && !is_md;
   assign done   = busy && count == CW'(1) && !bus.flush;
   always_comb begin
      alu_res = '0;
      case (bus.alu_op)
         2'b00: alu_res = op_a + op_b;
         2'b01: alu_res = op_a - op_b;
         2'b11: alu_res = op_a | op_b;
         default:
            case (bus.funct)
               6'h20, 6'h21: alu_res = op_a + op_b;
               6'h22, 6'h23: alu_res = op_a - op_b;
               6'h24:        alu_res = op_a & op_b;
               6'h25:        alu_res = op_a | op_b;
               6'h26:        alu_res = op_a ^ op_b;
               6'h27:        alu_res = ~(op_a | op_b);
               6'h2A:        alu_res = {{(DATA_W-1){1'b0}}, $signed(op_a) < $signed(op_b)};
               6'h2B:        alu_res = {{(DATA_W-1){1'b0}}, op_a < op_b};
               6'h10:        alu_res = hi;
               6'h12:        alu_res = lo;
               default:      alu_res = '0;
            endcase
      endcase
   end
   // The MDU works on magnitudes; signs are re-applied when the final step lands in HI/LO
   assign sgn   = !bus.funct[0];
   assign a_neg = sgn && op_a[DATA_W-1];
   assign b_neg = sgn && op_b[DATA_W-1];
   assign a_mag = a_neg ? -op_a : op_a;
   assign b_mag = b_neg ? -op_b : op_b;
   always_comb begin
      mul_sum  = {1'b0, p[2*DATA_W-1:DATA_W]} + (p[0] ? {1'b0, m} : '0);
      div_sh   = {p[2*DATA_W-1:DATA_W], p[DATA_W-1]};
      div_diff = div_sh - {1'b0, m};
      p_step   = !is_div ? {mul_sum, p[DATA_W-1:1]} :
                 div_diff[DATA_W] ? {div_sh[DATA_W-1:0], p[DATA_W-2:0], 1'b0} :
                 {div_diff[DATA_W-1:0], p[DATA_W-2:0], 1'b1};
      prod     = neg_q ? -p_step : p_step;
      q_fix    = neg_q ? -p_step[DATA_W-1:0] : p_step[DATA_W-1:0];
      r_fix    = neg_r ? -p_step[2*DATA_W-1:DATA_W] : p_step[2*DATA_W-1:DATA_W];
      lo_nxt   = !is_div ? prod[DATA_W-1:0] : div0 ? '1 : q_fix;
      hi_nxt   = !is_div ? prod[2*DATA_W-1:DATA_W] : div0 ? a_orig : r_fix;
   end
   always_comb state_nxt = bus.flush ? IDLE : md_go ? RUN : done ? IDLE : state;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_nxt;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi            <= '0;
         lo            <= '0;
         p             <= '0;
         m             <= '0;
         a_orig        <= '0;
         count         <= '0;
         is_div        <= 1'b0;
         neg_q         <= 1'b0;
         neg_r         <= 1'b0;
         div0          <= 1'b0;
         ex_valid      <= 1'b0;
         ex_alu_result <= '0;
         ex_store_data <= '0;
         ex_reg_dest   <= '0;
      end else begin
         if (md_go) begin
            p      <= {{DATA_W{1'b0}}, bus.funct[1] ? a_mag : b_mag};
            m      <= bus.funct[1] ? b_mag : a_mag;
            a_orig <= op_a;
            count  <= CW'(DATA_W);
            is_div <= bus.funct[1];
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            div0   <= op_b == '0;
         end else if (busy) begin
            p     <= p_step;
            count <= count - CW'(1);
         end
         if (done) begin
            hi <= hi_nxt;
            lo <= lo_nxt;
         end
         ex_valid <= alu_go;
         if (alu_go) begin
            ex_alu_result <= alu_res;
            ex_store_data <= fwd_b;
            ex_reg_dest   <= bus.reg_dst ? bus.id_rd : bus.id_rt;
         end
      end
   end
   assign bus.ex_stall      = stall;
   assign bus.ex_valid      = ex_valid;
   assign bus.ex_alu_result = ex_alu_result;
   assign bus.ex_store_data = ex_store_data;
   assign bus.ex_reg_dest   = ex_reg_dest;
endmodule

// File: tb/tb_ex_stage_md.sv
// tb_ex_stage_md: directed vectors for ex_stage_md; expected results queued, popped by a monitor
module tb_ex_stage_md;
   typedef struct {
      logic [31:0] res;
      logic [31:0] st;
      logic [4:0]  dest;
      string       nm;
   } exp_t;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   errors = 0;
   int   checks = 0;
   int   stall_valid = 0;
   int   s;
   exp_t sb[$];
   exp_t mon_e;
   ex_stage_md_if #(.DATA_W(32), .REG_AW(5)) bus ();
   ex_stage_md #(.DATA_W(32), .REG_AW(5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;
   always @(negedge clk) begin
      if (rst_n && bus.ex_valid) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_valid: got res=%h dst=%0d, expected no output", bus.ex_alu_result, bus.ex_reg_dest);
         end else begin
            mon_e = sb.pop_front();
            if (bus.ex_alu_result !== mon_e.res || bus.ex_store_data !== mon_e.st || bus.ex_reg_dest !== mon_e.dest) begin
               errors++;
               $display("FAIL %s: got res=%h st=%h dst=%0d, expected res=%h st=%h dst=%0d", mon_e.nm,
                        bus.ex_alu_result, bus.ex_store_data, bus.ex_reg_dest, mon_e.res, mon_e.st, mon_e.dest);
            end
         end
      end
   end
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask
   task automatic set_op(input logic [1:0] aop, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
      bus.alu_op = aop;
      bus.funct = f;
      bus.id_read_data1 = a;
      bus.id_read_data2 = b;
      bus.id_imm = 32'h0;
      bus.id_rt = 5'd4;
      bus.id_rd = 5'd3;
      bus.alu_src = 1'b0;
      bus.reg_dst = 1'b1;
      bus.forward_a = 2'b00;
      bus.forward_b = 2'b00;
      bus.mem_fwd_data = 32'h0;
      bus.wb_fwd_data = 32'h0;
   endtask
   // Holds in_valid until the stage accepts; reports how many edges it was held off
   task automatic send(input logic push, input logic [31:0] er, input logic [31:0] es, input logic [4:0] ed,
                       input string nm, output int stalls);
      logic st;
      exp_t e;
      if (push) begin
         e.res = er;
         e.st = es;
         e.dest = ed;
         e.nm = nm;
         sb.push_back(e);
      end
      bus.in_valid = 1'b1;
      stalls = 0;
      do begin
         @(negedge clk);
         st = bus.ex_stall;
         if (st) begin
            stalls++;
            if (bus.ex_valid) stall_valid++;
         end
         @(posedge clk);
         #1;
      end while (st && stalls < 100);
      bus.in_valid = 1'b0;
   endtask
   task automatic alu(input logic [1:0] aop, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] er, input string nm);
      int st;
      set_op(aop, f, a, b);
      send(1'b1, er, b, 5'd3, nm, st);
   endtask
   task automatic md(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b, input int es, input string nm);
      int st;
      set_op(2'b10, f, a, b);
      send(1'b0, 32'h0, 32'h0, 5'd0, nm, st);
      chk(nm, st, es);
   endtask
   task automatic rd(input logic [5:0] f, input logic [31:0] er, input int es, input string nm);
      int st;
      set_op(2'b10, f, 32'h0, 32'h0);
      send(1'b1, er, 32'h0, 5'd3, nm, st);
      chk({nm, "_stalls"}, st, es);
   endtask
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not reach the end");
      $fatal(1, "timeout");
   end
   initial begin
      bus.in_valid = 1'b0;
      bus.flush = 1'b0;
      set_op(2'b00, 6'h0, 32'h0, 32'h0);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", bus.ex_valid, 0);
      chk("rst_result", bus.ex_alu_result, 0);
      chk("rst_store", bus.ex_store_data, 0);
      chk("rst_dest", bus.ex_reg_dest, 0);
      chk("rst_stall", bus.ex_stall, 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      set_op(2'b10, 6'h20, 32'd5, 32'd3);
      bus.mem_fwd_data = 32'd7;
      bus.forward_a = 2'b10;
      bus.id_rd = 5'd9;
      send(1'b1, 32'd10, 32'd3, 5'd9, "fwd_mem_add", s);
      set_op(2'b10, 6'h22, 32'd5, 32'd3);
      bus.mem_fwd_data = 32'd7;
      bus.forward_b = 2'b10;
      send(1'b1, 32'hFFFF_FFFE, 32'd7, 5'd3, "fwd_b_sub", s);
      set_op(2'b00, 6'h0, 32'd5, 32'd3);
      bus.alu_src = 1'b1;
      bus.id_imm = 32'h10;
      bus.reg_dst = 1'b0;
      send(1'b1, 32'h15, 32'd3, 5'd4, "imm_add_rt", s);
      set_op(2'b11, 6'h0, 32'h30, 32'h0F);
      bus.forward_a = 2'b01;
      bus.wb_fwd_data = 32'h100;
      send(1'b1, 32'h10F, 32'h0F, 5'd3, "fwd_wb_or", s);
      set_op(2'b10, 6'h24, 32'hF0F0, 32'hFF00);
      bus.forward_a = 2'b11;
      bus.mem_fwd_data = 32'hFFFF;
      bus.wb_fwd_data = 32'hFFFF;
      send(1'b1, 32'hF000, 32'hFF00, 5'd3, "fwd_rsv_and", s);
      alu(2'b10, 6'h2A, 32'hFFFF_FFFF, 32'd1, 32'd1, "slt");
      alu(2'b10, 6'h2B, 32'hFFFF_FFFF, 32'd1, 32'd0, "sltu");
      alu(2'b10, 6'h27, 32'h0, 32'h0, 32'hFFFF_FFFF, "nor");
      alu(2'b10, 6'h3F, 32'h1234, 32'h5678, 32'h0, "funct_3f");
      alu(2'b10, 6'h26, 32'hFF, 32'h0F, 32'hF0, "xor");
      alu(2'b01, 6'h0, 32'd3, 32'd5, 32'hFFFF_FFFE, "aluop_sub");
      md(6'h18, 32'hFFFF_FFFD, 32'd7, 0, "mult_accept");
      rd(6'h10, 32'hFFFF_FFFF, 32, "mult_mfhi");
      rd(6'h12, 32'hFFFF_FFEB, 0, "mult_mflo");
      md(6'h1B, 32'd100, 32'd7, 0, "divu_accept");
      rd(6'h12, 32'd14, 32, "divu_mflo");
      rd(6'h10, 32'd2, 0, "divu_mfhi");
      md(6'h19, 32'd1, 32'd1, 0, "multu_pre");
      md(6'h1A, 32'hFFFF_FFF9, 32'd2, 32, "div_held");
      rd(6'h12, 32'hFFFF_FFFD, 32, "div_mflo");
      rd(6'h10, 32'hFFFF_FFFF, 0, "div_mfhi");
      md(6'h1A, 32'd9, 32'd0, 0, "div0_accept");
      rd(6'h12, 32'hFFFF_FFFF, 32, "div0_mflo");
      rd(6'h10, 32'd9, 0, "div0_mfhi");
      md(6'h1A, 32'h8000_0000, 32'hFFFF_FFFF, 0, "divmin_accept");
      rd(6'h12, 32'h8000_0000, 32, "divmin_mflo");
      rd(6'h10, 32'h0, 0, "divmin_mfhi");
      md(6'h19, 32'd2, 32'h8000_0001, 0, "multu_accept");
      rd(6'h10, 32'd1, 32, "multu_mfhi");
      rd(6'h12, 32'd2, 0, "multu_mflo");
      md(6'h19, 32'd3, 32'd5, 0, "multu_flushed");
      repeat (4) @(posedge clk);
      #1;
      bus.flush = 1'b1;
      @(posedge clk);
      #1;
      bus.flush = 1'b0;
      bus.in_valid = 1'b1;
      #1;
      chk("flush_stall", bus.ex_stall, 0);
      bus.in_valid = 1'b0;
      rd(6'h10, 32'd1, 0, "flush_mfhi");
      rd(6'h12, 32'd2, 0, "flush_mflo");
      set_op(2'b00, 6'h0, 32'd1, 32'd1);
      bus.in_valid = 1'b1;
      bus.flush = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.flush = 1'b0;
      @(negedge clk);
      chk("flush_alu_valid", bus.ex_valid, 0);
      @(posedge clk);
      #1;
      alu(2'b00, 6'h0, 32'h11, 32'h22, 32'h33, "pre_rst_add");
      md(6'h1B, 32'd50, 32'd7, 0, "rst_divu_accept");
      repeat (3) @(posedge clk);
      #3;
      rst_n = 1'b0;
      bus.in_valid = 1'b1;
      bus.funct = 6'h10;
      #1;
      chk("arst_valid", bus.ex_valid, 0);
      chk("arst_result", bus.ex_alu_result, 0);
      chk("arst_store", bus.ex_store_data, 0);
      chk("arst_dest", bus.ex_reg_dest, 0);
      chk("arst_stall", bus.ex_stall, 0);
      bus.in_valid = 1'b0;
      #3;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      rd(6'h10, 32'h0, 0, "arst_mfhi");
      rd(6'h12, 32'h0, 0, "arst_mflo");
      repeat (3) @(posedge clk);
      #1;
      chk("sb_drained", sb.size(), 0);
      chk("stall_bubbles", stall_valid, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
